// File: rtl/instr_issue_queue.sv
// Out-of-order issue queue: collapsing slot array with wakeup tracking and oldest-ready select.
// Optional IQ_WAKEUP_BYPASS_EN: same-cycle wakeups feed select directly.
package instr_issue_queue_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  opcode;
    logic [5:0]  rd_phys;
    logic [5:0]  rs_phys;
    logic [5:0]  rt_phys;
    logic        uses_rs;
    logic        uses_rt;
    logic        is_mem_access;
    logic        is_branch;
    logic        ready;
    logic [31:0] count;
  } Instr_Queue_Entry_t;

endpackage

module instr_issue_queue
  import instr_issue_queue_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int WAKEUP_PORTS = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_flush,
  input  logic                         i_enq_valid,
  output logic                         o_enq_ready,
  input  Instr_Queue_Entry_t           i_enq_entry,
  input  logic                         i_enq_rs_ready,
  input  logic                         i_enq_rt_ready,
  input  logic [WAKEUP_PORTS-1:0]      i_wb_valid,
  input  logic [WAKEUP_PORTS*6-1:0]    i_wb_reg,
  output logic                         o_issue_valid,
  input  logic                         i_issue_ready,
  output Instr_Queue_Entry_t           o_issue_entry,
  output logic [$clog2(DEPTH+1)-1:0]   o_occupancy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  function automatic logic wake_hit(
    input logic [WAKEUP_PORTS-1:0]   valid,
    input logic [WAKEUP_PORTS*6-1:0] regs,
    input logic [5:0]                tag
  );
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < WAKEUP_PORTS; p++) begin
      hit = hit | (valid[p] & (regs[p*6 +: 6] == tag));
    end
    return hit;
  endfunction

  logic [DEPTH-1:0]   r_valid;
  logic [DEPTH-1:0]   r_rs_rdy;
  logic [DEPTH-1:0]   r_rt_rdy;
  Instr_Queue_Entry_t r_entry [DEPTH];
  logic [31:0]        r_cnt   [DEPTH];
  logic [OCC_W-1:0]   r_occ;

  logic [DEPTH-1:0]   w_rs_wake;
  logic [DEPTH-1:0]   w_rt_wake;
  logic [DEPTH-1:0]   w_rs_eff;
  logic [DEPTH-1:0]   w_rt_eff;
  logic [DEPTH-1:0]   w_slot_rdy;
  logic               w_found;
  logic               w_mem_older;
  logic [IDX_W-1:0]   w_sel_idx;
  logic               w_issue_fire;
  logic               w_enq_ready;
  logic               w_enq_fire;
  logic [IDX_W-1:0]   w_enq_idx;
  logic               w_enq_rs_rdy;
  logic               w_enq_rt_rdy;

  logic [DEPTH-1:0]   w_nxt_valid;
  logic [DEPTH-1:0]   w_nxt_rs_rdy;
  logic [DEPTH-1:0]   w_nxt_rt_rdy;
  Instr_Queue_Entry_t w_nxt_entry [DEPTH];
  logic [31:0]        w_nxt_cnt   [DEPTH];
  logic [OCC_W-1:0]   w_nxt_occ;

  // Per-slot wakeup detection and the readiness seen by select.
  always_comb begin
    w_rs_wake  = '0;
    w_rt_wake  = '0;
    w_rs_eff   = '0;
    w_rt_eff   = '0;
    w_slot_rdy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_rs_wake[i] = wake_hit(i_wb_valid, i_wb_reg, r_entry[i].rs_phys);
      w_rt_wake[i] = wake_hit(i_wb_valid, i_wb_reg, r_entry[i].rt_phys);
`ifdef IQ_WAKEUP_BYPASS_EN
      w_rs_eff[i] = r_rs_rdy[i] | w_rs_wake[i];
      w_rt_eff[i] = r_rt_rdy[i] | w_rt_wake[i];
`else
      w_rs_eff[i] = r_rs_rdy[i];
      w_rt_eff[i] = r_rt_rdy[i];
`endif
      w_slot_rdy[i] = r_valid[i]
                    & (~r_entry[i].uses_rs | w_rs_eff[i])
                    & (~r_entry[i].uses_rt | w_rt_eff[i]);
    end
  end

  // Oldest-ready select; memory ops may not pass an older memory op.
  always_comb begin
    w_found     = 1'b0;
    w_mem_older = 1'b0;
    w_sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!w_found && w_slot_rdy[i] && !(r_entry[i].is_mem_access && w_mem_older)) begin
        w_found   = 1'b1;
        w_sel_idx = IDX_W'(i);
      end else begin
        w_found   = w_found;
      end
      w_mem_older = w_mem_older | (r_valid[i] & r_entry[i].is_mem_access);
    end
  end

  assign w_issue_fire = w_found & i_issue_ready;
  assign w_enq_ready  = (r_occ < FULL_OCC);
  assign w_enq_fire   = i_enq_valid & w_enq_ready;
  assign w_enq_idx    = w_issue_fire ? IDX_W'(r_occ - OCC_W'(1)) : IDX_W'(r_occ);
  assign w_enq_rs_rdy = i_enq_rs_ready | (i_enq_entry.rs_phys == 6'd0)
                      | wake_hit(i_wb_valid, i_wb_reg, i_enq_entry.rs_phys);
  assign w_enq_rt_rdy = i_enq_rt_ready | (i_enq_entry.rt_phys == 6'd0)
                      | wake_hit(i_wb_valid, i_wb_reg, i_enq_entry.rt_phys);

  // Collapse above the issued slot, apply wakeups, age counters, then insert.
  always_comb begin
    int src;
    src          = 0;
    w_nxt_valid  = '0;
    w_nxt_rs_rdy = '0;
    w_nxt_rt_rdy = '0;
    for (int j = 0; j < DEPTH; j++) begin
      w_nxt_entry[j] = r_entry[j];
      w_nxt_cnt[j]   = 32'd0;
    end
    for (int j = 0; j < DEPTH; j++) begin
      src = (w_issue_fire && (j >= int'(w_sel_idx))) ? j + 1 : j;
      if (src < DEPTH) begin
        w_nxt_valid[j]  = r_valid[src];
        w_nxt_entry[j]  = r_entry[src];
        w_nxt_rs_rdy[j] = r_rs_rdy[src] | w_rs_wake[src];
        w_nxt_rt_rdy[j] = r_rt_rdy[src] | w_rt_wake[src];
        w_nxt_cnt[j]    = (r_cnt[src] == 32'hFFFF_FFFF) ? r_cnt[src] : r_cnt[src] + 32'd1;
      end else begin
        w_nxt_valid[j]  = 1'b0;
      end
    end
    if (w_enq_fire) begin
      w_nxt_valid[w_enq_idx]  = 1'b1;
      w_nxt_entry[w_enq_idx]  = i_enq_entry;
      w_nxt_rs_rdy[w_enq_idx] = w_enq_rs_rdy;
      w_nxt_rt_rdy[w_enq_idx] = w_enq_rt_rdy;
      w_nxt_cnt[w_enq_idx]    = 32'd0;
    end else begin
      w_nxt_valid = w_nxt_valid;
    end
    case ({w_enq_fire, w_issue_fire})
      2'b10:   w_nxt_occ = r_occ + OCC_W'(1);
      2'b01:   w_nxt_occ = r_occ - OCC_W'(1);
      default: w_nxt_occ = r_occ;
    endcase
  end

  // Slot state; flush squashes exactly like reset.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_valid  <= '0;
      r_rs_rdy <= '0;
      r_rt_rdy <= '0;
      r_occ    <= '0;
      for (int j = 0; j < DEPTH; j++) begin
        r_cnt[j] <= 32'd0;
      end
    end else begin
      r_valid  <= w_nxt_valid;
      r_rs_rdy <= w_nxt_rs_rdy;
      r_rt_rdy <= w_nxt_rt_rdy;
      r_occ    <= w_nxt_occ;
      for (int j = 0; j < DEPTH; j++) begin
        r_entry[j] <= w_nxt_entry[j];
        r_cnt[j]   <= w_nxt_cnt[j];
      end
    end
  end

  // Present the selected slot with its accumulated wait count.
  always_comb begin
    o_issue_entry       = r_entry[w_sel_idx];
    o_issue_entry.ready = 1'b1;
    o_issue_entry.count = r_cnt[w_sel_idx];
  end

  assign o_issue_valid = w_found;
  assign o_enq_ready   = w_enq_ready;
  assign o_occupancy   = r_occ;

endmodule

// File: tb/tb_instr_issue_queue.sv
// Table-driven bench for instr_issue_queue; issue order and wait counts checked by a scoreboard.
module tb_instr_issue_queue;
  import instr_issue_queue_pkg::*;

`ifdef IQ_WAKEUP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               flush;
  logic               enq_valid;
  logic               enq_ready;
  Instr_Queue_Entry_t enq_entry;
  logic               enq_rs_ready;
  logic               enq_rt_ready;
  logic [1:0]         wb_valid;
  logic [11:0]        wb_reg;
  logic               issue_valid;
  logic               issue_ready;
  Instr_Queue_Entry_t issue_entry;
  logic [3:0]         occupancy;

  instr_issue_queue #(.DEPTH(8), .WAKEUP_PORTS(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_enq_valid(enq_valid), .o_enq_ready(enq_ready), .i_enq_entry(enq_entry),
    .i_enq_rs_ready(enq_rs_ready), .i_enq_rt_ready(enq_rt_ready),
    .i_wb_valid(wb_valid), .i_wb_reg(wb_reg),
    .o_issue_valid(issue_valid), .i_issue_ready(issue_ready),
    .o_issue_entry(issue_entry), .o_occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          enq;
    logic [31:0] pc;
    logic [5:0]  rs;
    logic [5:0]  rt;
    bit          mem;
    bit          rsr;
    bit          rtr;
    bit          wbv;
    logic [5:0]  wbr;
    bit          irdy;
    bit          flush;
    bit          exp_iv;
    int          exp_occ;
    bit          exp_er;
    logic [31:0] push_pc;
    int          push_cnt;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    int          cnt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(input bit enq, input logic [31:0] pc, input logic [5:0] rs,
                              input logic [5:0] rt, input bit mem, input bit rsr, input bit rtr,
                              input bit wbv, input logic [5:0] wbr, input bit irdy, input bit fl,
                              input bit iv, input int occ, input bit er,
                              input logic [31:0] push_pc, input int push_cnt);
    vec_t v;
    v.enq = enq; v.pc = pc; v.rs = rs; v.rt = rt; v.mem = mem; v.rsr = rsr; v.rtr = rtr;
    v.wbv = wbv; v.wbr = wbr; v.irdy = irdy; v.flush = fl; v.exp_iv = iv; v.exp_occ = occ;
    v.exp_er = er; v.push_pc = push_pc; v.push_cnt = push_cnt;
    vecs.push_back(v);
  endfunction

  function automatic void idle(input bit irdy, input bit iv, input int occ, input logic [31:0] push_pc);
    add(1'b0, 32'h0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, irdy, 1'b0, iv, occ, 1'b1, push_pc, -1);
  endfunction

  // Scoreboard: every accepted issue must match the next expected entry.
  always @(negedge clk) begin
    if (!rst && issue_valid && issue_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_issue_pc", {32'h0, issue_entry.pc}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("issue_pc", {32'h0, issue_entry.pc}, {32'h0, e.pc});
        check("issue_ready_flag", {63'h0, issue_entry.ready}, 64'd1);
        if (e.cnt >= 0) check("issue_count", {32'h0, issue_entry.count}, {32'h0, e.cnt[31:0]});
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; enq_valid = 1'b0; enq_entry = '0;
    enq_rs_ready = 1'b0; enq_rt_ready = 1'b0; wb_valid = 2'b00; wb_reg = 12'h0; issue_ready = 1'b0;

    // ADDU held three cycles then accepted with count 3
    add(1'b1, 32'h10, 6'd8, 6'd9, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 32'h10, 3);
    idle(1'b0, 1'b1, 1, 32'h0);
    idle(1'b0, 1'b1, 1, 32'h0);
    idle(1'b0, 1'b1, 1, 32'h0);
    idle(1'b1, 1'b1, 1, 32'h0);
    idle(1'b1, 1'b0, 0, 32'h0);
    // A waits on tag 10, younger B passes it; wakeup then releases A
    add(1'b1, 32'h20, 6'd10, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 32'h24, 0);
    add(1'b1, 32'h24, 6'd11, 6'd12, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1, 1'b1, 32'h0, -1);
    idle(1'b1, 1'b1, 2, 32'h20);
    add(1'b0, 32'h0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd10, 1'b1, 1'b0, BYP, 1, 1'b1, 32'h0, -1);
    idle(1'b1, !BYP, BYP ? 0 : 1, 32'h0);
    idle(1'b1, 1'b0, 0, 32'h0);
    // LW not ready blocks a ready younger SW
    add(1'b1, 32'h30, 6'd13, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 32'h30, -1);
    add(1'b1, 32'h34, 6'd14, 6'd15, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1, 1'b1, 32'h0, -1);
    idle(1'b1, 1'b0, 2, 32'h34);
    idle(1'b1, 1'b0, 2, 32'h0);
    add(1'b0, 32'h0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd13, 1'b1, 1'b0, BYP, 2, 1'b1, 32'h0, -1);
    idle(1'b1, 1'b1, BYP ? 1 : 2, 32'h0);
    idle(1'b1, !BYP, BYP ? 0 : 1, 32'h0);
    idle(1'b1, 1'b0, 0, 32'h0);
    // Fill all eight slots, then issue with an enqueue that must be refused
    for (int k = 0; k < 8; k++) begin
      add(1'b1, 32'h40 + 32'(4 * k), 6'(k + 1), 6'(k + 2), 1'b0, 1'b1, 1'b1, 1'b0, 6'd0,
          1'b0, 1'b0, (k > 0), k, 1'b1, 32'h0, -1);
    end
    add(1'b1, 32'h60, 6'd1, 6'd2, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 1'b1, 8, 1'b0, 32'h40, 7);
    idle(1'b1, 1'b1, 7, 32'h44);
    idle(1'b1, 1'b1, 6, 32'h48);
    // Flush with five entries and a same-cycle enqueue
    add(1'b1, 32'h70, 6'd1, 6'd2, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 5, 1'b1, 32'h0, -1);
    idle(1'b1, 1'b0, 0, 32'h0);
    idle(1'b1, 1'b0, 0, 32'h0);
    // Wakeup arriving in the enqueue cycle is not lost
    add(1'b1, 32'h80, 6'd20, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd20, 1'b1, 1'b0, 1'b0, 0, 1'b1, 32'h80, 0);
    idle(1'b1, 1'b1, 1, 32'h0);
    idle(1'b1, 1'b0, 0, 32'h0);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_occupancy", {60'h0, occupancy}, 64'd0);
    check("reset_issue_valid", {63'h0, issue_valid}, 64'd0);
    check("reset_enq_ready", {63'h0, enq_ready}, 64'd1);
    @(posedge clk);
    #1;

    for (int k = 0; k < vecs.size(); k++) begin
      vec_t v;
      exp_t e;
      v = vecs[k];
      enq_valid           = v.enq;
      enq_entry           = '0;
      enq_entry.pc        = v.pc;
      enq_entry.rs_phys   = v.rs;
      enq_entry.rt_phys   = v.rt;
      enq_entry.uses_rs   = 1'b1;
      enq_entry.uses_rt   = 1'b1;
      enq_entry.is_mem_access = v.mem;
      enq_rs_ready        = v.rsr;
      enq_rt_ready        = v.rtr;
      wb_valid            = {1'b0, v.wbv};
      wb_reg              = {6'd0, v.wbr};
      issue_ready         = v.irdy;
      flush               = v.flush;
      if (v.push_pc != 32'h0) begin
        e.pc  = v.push_pc;
        e.cnt = v.push_cnt;
        sb.push_back(e);
      end
      @(negedge clk);
      check($sformatf("row%0d_issue_valid", k), {63'h0, issue_valid}, {63'h0, v.exp_iv});
      check($sformatf("row%0d_occupancy", k), {60'h0, occupancy}, 64'(v.exp_occ));
      check($sformatf("row%0d_enq_ready", k), {63'h0, enq_ready}, {63'h0, v.exp_er});
      @(posedge clk);
      #1;
    end

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
